// File: rtl/ps2_mouse_init.sv
// PS/2 mouse initialisation sequencer.
// Brings the mouse out of power-up with a reset command (0xFF), checks the
// ACK / BAT / ID replies, enables streaming (0xF4), then forwards received
// bytes downstream. Failed replies, writer errors and timeouts restart the
// whole sequence a bounded number of times before latching a failure.
module ps2_mouse_init #(
  parameter logic [24:0] POWERUP_WAIT = 25'd14_000_000,
  parameter logic [24:0] TIMEOUT      = 25'd28_000_000,
  parameter logic [1:0]  MAX_RETRIES  = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  input  logic       tx_error,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] mouse_data,
  output logic       mouse_valid,
  output logic       init_done,
  output logic       init_fail
);

  typedef enum logic [3:0] {
    POWERUP      = 4'd0,
    SEND_RST     = 4'd1,
    WAIT_TX_RST  = 4'd2,
    WAIT_ACK_RST = 4'd3,
    WAIT_BAT     = 4'd4,
    WAIT_ID      = 4'd5,
    SEND_EN      = 4'd6,
    WAIT_TX_EN   = 4'd7,
    WAIT_ACK_EN  = 4'd8,
    DONE         = 4'd9,
    FAIL         = 4'd10
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  state_t      r_state;
  state_t      w_seq_next;
  state_t      w_next;
  logic [24:0] r_timer;
  logic [1:0]  r_retries;
  logic        r_busy_seen;
  logic        r_tx_load;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_mouse_data;
  logic        r_mouse_valid;
  logic        r_init_done;
  logic        r_init_fail;

  logic        w_retry;
  logic        w_tmo;
  logic        w_busy_fall;
  logic        w_entry;
  logic        w_timed;
  logic        w_wait_tx;
  logic        w_load_next;
  logic        w_pass;

  // Byte the mouse must send in a reply-wait state.
  function automatic logic [7:0] expected_reply(input state_t s);
    case (s)
      WAIT_ACK_RST: expected_reply = RSP_ACK;
      WAIT_BAT:     expected_reply = RSP_BAT;
      WAIT_ID:      expected_reply = RSP_ID;
      WAIT_ACK_EN:  expected_reply = RSP_ACK;
      default:      expected_reply = 8'h00;
    endcase
  endfunction

  // State that follows a correct reply.
  function automatic state_t reply_next(input state_t s);
    case (s)
      WAIT_ACK_RST: reply_next = WAIT_BAT;
      WAIT_BAT:     reply_next = WAIT_ID;
      WAIT_ID:      reply_next = SEND_EN;
      WAIT_ACK_EN:  reply_next = DONE;
      default:      reply_next = POWERUP;
    endcase
  endfunction

  assign w_tmo       = (r_timer == (TIMEOUT - 25'd1));
  assign w_busy_fall = r_busy_seen & ~tx_busy;
  assign w_wait_tx   = (r_state == WAIT_TX_RST) | (r_state == WAIT_TX_EN);
  assign w_timed     = (r_state != POWERUP) & (r_state != DONE) & (r_state != FAIL);

  // Next-state decode: sequence step, then retry handling, then restart on top.
  always_comb begin
    w_seq_next = r_state;
    w_retry    = 1'b0;
    w_next     = r_state;
    case (r_state)
      POWERUP: begin
        if (r_timer == (POWERUP_WAIT - 25'd1)) begin
          w_seq_next = SEND_RST;
        end else begin
          w_seq_next = POWERUP;
        end
      end
      SEND_RST, SEND_EN: begin
        // The load strobe is issued while sitting here; leave once it has gone out.
        if (r_tx_load) begin
          w_seq_next = (r_state == SEND_RST) ? WAIT_TX_RST : WAIT_TX_EN;
        end else if (w_tmo) begin
          w_retry = 1'b1;
        end else begin
          w_seq_next = r_state;
        end
      end
      WAIT_TX_RST, WAIT_TX_EN: begin
        if (w_busy_fall) begin
          if (tx_error) begin
            w_retry = 1'b1;
          end else begin
            w_seq_next = (r_state == WAIT_TX_RST) ? WAIT_ACK_RST : WAIT_ACK_EN;
          end
        end else if (w_tmo) begin
          w_retry = 1'b1;
        end else begin
          w_seq_next = r_state;
        end
      end
      WAIT_ACK_RST, WAIT_BAT, WAIT_ID, WAIT_ACK_EN: begin
        if (rx_valid) begin
          if (rx_data == expected_reply(r_state)) begin
            w_seq_next = reply_next(r_state);
          end else begin
            w_retry = 1'b1;
          end
        end else if (w_tmo) begin
          w_retry = 1'b1;
        end else begin
          w_seq_next = r_state;
        end
      end
      DONE:    w_seq_next = DONE;
      FAIL:    w_seq_next = FAIL;
      default: w_seq_next = POWERUP;
    endcase

    if (restart) begin
      w_next = SEND_RST;
    end else if (w_retry) begin
      w_next = (r_retries < MAX_RETRIES) ? SEND_RST : FAIL;
    end else begin
      w_next = w_seq_next;
    end
  end

  // A retry into SEND_RST from SEND_RST still counts as a fresh entry.
  assign w_entry = restart | w_retry | (w_next != r_state);

  // Issue a load only when the writer is idle and no load went out last cycle,
  // so the writer has a cycle to raise tx_busy before we look again.
  assign w_load_next = ((w_next == SEND_RST) | (w_next == SEND_EN)) & ~tx_busy & ~r_tx_load;

  assign w_pass = (r_state == DONE) & rx_valid & ~restart;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= POWERUP;
    end else begin
      r_state <= w_next;
    end
  end

  // Power-up delay / per-state timeout counter, cleared on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= 25'd0;
    end else if (w_entry) begin
      r_timer <= 25'd0;
    end else if ((r_state == POWERUP) | w_timed) begin
      r_timer <= r_timer + 25'd1;
    end else begin
      r_timer <= 25'd0;
    end
  end

  // Tracks that the writer has gone busy, so the following low is the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_seen <= 1'b0;
    end else if (w_entry) begin
      r_busy_seen <= 1'b0;
    end else if (w_wait_tx) begin
      r_busy_seen <= r_busy_seen | tx_busy;
    end else begin
      r_busy_seen <= 1'b0;
    end
  end

  // Saturating retry counter, cleared by restart and on entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retries <= 2'd0;
    end else if (restart) begin
      r_retries <= 2'd0;
    end else if ((w_next == DONE) && (r_state != DONE)) begin
      r_retries <= 2'd0;
    end else if (w_retry && (r_retries < MAX_RETRIES)) begin
      r_retries <= r_retries + 2'd1;
    end else begin
      r_retries <= r_retries;
    end
  end

  // Writer command interface; the command byte holds until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_load <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_load <= w_load_next;
      if (w_load_next) begin
        r_tx_data <= (w_next == SEND_RST) ? CMD_RESET : CMD_ENABLE;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  // Downstream pass-through, open only while initialisation is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mouse_valid <= 1'b0;
      r_mouse_data  <= 8'h00;
    end else begin
      r_mouse_valid <= w_pass;
      if (w_pass) begin
        r_mouse_data <= rx_data;
      end else begin
        r_mouse_data <= r_mouse_data;
      end
    end
  end

  // Status levels, aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
      r_init_fail <= 1'b0;
    end else begin
      r_init_done <= (w_next == DONE);
      r_init_fail <= (w_next == FAIL);
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_load     = r_tx_load;
  assign mouse_data  = r_mouse_data;
  assign mouse_valid = r_mouse_valid;
  assign init_done   = r_init_done;
  assign init_fail   = r_init_fail;

endmodule

// File: doc/ps2_mouse_init.md
PS2_MOUSE_INIT -- requirements
Module: ps2_mouse_init

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter POWERUP_WAIT, default 25'd14_000_000, giving the cycles idled after reset before the first command.
REQ-002 The block SHALL have parameter TIMEOUT, default 25'd28_000_000, giving the maximum cycles spent in any wait state.
REQ-003 The block SHALL have parameter MAX_RETRIES, default 2'd3, giving the number of full-sequence restarts allowed before failure.

Ports, one per line: name, direction, width, meaning.
REQ-004 The block SHALL have clk, input, 1, the single system clock; every flop is clocked on its rising edge.
REQ-005 The block SHALL have rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have restart, input, 1, a one-cycle pulse that restarts the init sequence from SEND_RST.
REQ-007 The block SHALL have rx_data, input, 8, the byte received from the PS/2 receiver.
REQ-008 The block SHALL have rx_valid, input, 1, a one-cycle strobe marking rx_data as valid.
REQ-009 The block SHALL have tx_busy, input, 1, high while the host-to-device writer is transmitting.
REQ-010 The block SHALL have tx_error, input, 1, the writer's error flag, sampled when tx_busy falls.
REQ-011 The block SHALL have tx_data, output, 8, the command byte for the writer.
REQ-012 The block SHALL have tx_load, output, 1, a one-cycle load strobe for the writer.
REQ-013 The block SHALL have mouse_data, output, 8, the received byte passed downstream to the packet translator.
REQ-014 The block SHALL have mouse_valid, output, 1, the downstream strobe, asserted only once init is complete.
REQ-015 The block SHALL have init_done, output, 1, a level that is high in the DONE state.
REQ-016 The block SHALL have init_fail, output, 1, a level that is high in the FAIL state.

Function
REQ-017 The FSM SHALL have these states: POWERUP, SEND_RST, WAIT_TX_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_TX_EN, WAIT_ACK_EN, DONE, FAIL.
REQ-018 POWERUP SHALL count POWERUP_WAIT cycles, then go to SEND_RST.
REQ-019 SEND_RST SHALL drive tx_data=0xFF and tx_load=1 for exactly one cycle, then go to WAIT_TX_RST; SEND_EN SHALL do the same with 0xF4 and go to WAIT_TX_EN.
REQ-020 In each WAIT_TX_* state the FSM SHALL first wait for tx_busy=1, then for tx_busy=0.
  - On the falling edge with tx_error=0: advance to the matching WAIT_ACK_*.
  - With tx_error=1: go to RETRY handling.
REQ-021 WAIT_ACK_RST SHALL require rx_data=0xFA, then go to WAIT_BAT.
REQ-022 WAIT_BAT SHALL require 0xAA, then go to WAIT_ID.
REQ-023 WAIT_ID SHALL require 0x00, then go to SEND_EN.
REQ-024 WAIT_ACK_EN SHALL require 0xFA, then go to DONE.
REQ-025 Any rx_valid byte that does not match the expected value in a WAIT_ACK/BAT/ID state SHALL go to RETRY handling.
REQ-026 Every state except POWERUP, DONE and FAIL SHALL run a 25-bit timeout counter that clears on state entry; when the counter reaches TIMEOUT-1 without the state's exit condition, RETRY handling SHALL apply.
REQ-027 RETRY handling SHALL increment the retry count and go to SEND_RST if retries < MAX_RETRIES; otherwise it SHALL go to FAIL.
REQ-028 The retry counter SHALL saturate and SHALL clear on entering DONE or on restart.
REQ-029 If an exit condition and a timeout occur in the same cycle, the exit condition SHALL take priority.
REQ-030 In DONE, mouse_valid SHALL equal rx_valid delayed by one cycle, and mouse_data SHALL be rx_data registered in that same cycle.
REQ-031 In every state other than DONE, mouse_valid SHALL be held at 0, so init bytes never reach the translator.
REQ-032 restart SHALL take effect from any state, including DONE and FAIL: the next state is SEND_RST, the retry count is cleared, the timeout counter is cleared, and any pending tx wait is abandoned.
REQ-033 restart SHALL have priority over rx_valid and timeout in the same cycle.
REQ-034 tx_load SHALL never be asserted while tx_busy=1.
REQ-035 tx_data SHALL hold its value until the next load.

Reset
REQ-036 While rst_n=0, the FSM SHALL be in POWERUP, all counters SHALL be 0, tx_data=0x00, tx_load=0, mouse_data=0x00, mouse_valid=0, init_done=0, init_fail=0.
REQ-037 Reset assertion mid-transmission SHALL abort the sequence immediately.
REQ-038 After reset is released, operation SHALL resume from POWERUP with a full POWERUP_WAIT.

Verification
REQ-039 Nominal case: with POWERUP_WAIT=10 and TIMEOUT=100, a writer model and a mouse model answering FA, AA, 00, then FA -> tx_load pulses carry 0xFF then 0xF4, init_done=1, and a later byte 0x08 produces mouse_valid with mouse_data=0x08.
REQ-040 Bad BAT: the mouse answers FA, FC to 0xFF -> 0xFF is re-sent; after a correct second sequence, init_done=1 and the retry count is 0.
REQ-041 Silent device: no rx bytes ever arrive, MAX_RETRIES=3 -> four 0xFF loads, then init_fail=1 and no further tx_load.
REQ-042 Writer error: tx_error=1 at the tx_busy fall of 0xF4 -> the sequence restarts at 0xFF.
REQ-043 Restart from DONE: a restart pulse in the same cycle as rx_valid -> mouse_valid stays 0, init_done falls next cycle, and 0xFF is loaded.
REQ-044 Reset mid-WAIT_BAT: rst_n is asserted -> all outputs read 0 at once, and after release there are POWERUP_WAIT idle cycles before 0xFF is loaded.
